// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op encoding, flag layout and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_SLL = 3'd4,
    OP_SRA = 3'd5,
    OP_MUL = 3'd6,
    OP_XOR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_NEG   = 2;
  localparam int FLAG_CARRY = 1;
  localparam int FLAG_OVF   = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_HOLD = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative radix-2 Booth signed multiplier: one add/sub-and-shift per cycle,
// WIDTH cycles per product; done and prod are valid during the final step.
module alu_mul_iter #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   lhs,
  input  logic [WIDTH-1:0]   rhs,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH:0]   acc_q, acc_d, mcand_q, sum;
  logic [WIDTH-1:0] mpr_q, mpr_d;
  logic             qm1_q, qm1_d;
  logic             busy_q;
  logic [CW-1:0]    cnt_q;

  // The accumulator carries one guard bit so adding/subtracting the most
  // negative multiplicand can never wrap before the arithmetic shift.
  always_comb begin
    sum = acc_q;
    case ({mpr_q[0], qm1_q})
      2'b01:   sum = acc_q + mcand_q;
      2'b10:   sum = acc_q - mcand_q;
      default: sum = acc_q;
    endcase
    {acc_d, mpr_d, qm1_d} = {sum[WIDTH], sum, mpr_q};
  end

  assign done = busy_q && (cnt_q == CW'(WIDTH - 1));
  assign prod = {acc_d[WIDTH-1:0], mpr_d};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      mcand_q <= '0;
      mpr_q   <= '0;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (start) begin
      acc_q   <= '0;
      mcand_q <= {lhs[WIDTH-1], lhs};
      mpr_q   <= rhs;
      qm1_q   <= 1'b0;
      busy_q  <= 1'b1;
      cnt_q   <= '0;
    end else if (busy_q) begin
      acc_q <= acc_d;
      mpr_q <= mpr_d;
      qm1_q <= qm1_d;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle ops register on the accept edge, MUL runs on the
// iterative multiplier; one op in flight, result held until the consumer takes it.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;

  alu_op_e          opE;
  logic             accept;
  logic             mulStart, mulDone, mulOvf;
  logic [2*WIDTH-1:0] mulProd;

  logic [WIDTH-1:0] addB, dpRes, ldRes;
  logic [WIDTH:0]   addSum;
  logic             addCin, dpCarry, dpOvf, ldCarry, ldOvf, load;

  assign opE       = alu_op_e'(op);
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == ST_HOLD);
  assign result    = result_q;
  assign flags     = flags_q;

  // SUB reuses the adder as lhs + ~rhs + 1, so carry means "no borrow".
  always_comb begin
    addB    = (opE == OP_SUB) ? ~rhs : rhs;
    addCin  = (opE == OP_SUB);
    addSum  = {1'b0, lhs} + {1'b0, addB} + {{WIDTH{1'b0}}, addCin};
    dpRes   = '0;
    dpCarry = 1'b0;
    dpOvf   = 1'b0;
    case (opE)
      OP_ADD, OP_SUB: begin
        dpRes   = addSum[WIDTH-1:0];
        dpCarry = addSum[WIDTH];
        dpOvf   = (lhs[WIDTH-1] == addB[WIDTH-1]) && (addSum[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_AND:  dpRes = lhs & rhs;
      OP_OR:   dpRes = lhs | rhs;
      OP_XOR:  dpRes = lhs ^ rhs;
      OP_SLL:  dpRes = lhs << rhs[SHW-1:0];
      OP_SRA:  dpRes = $unsigned($signed(lhs) >>> rhs[SHW-1:0]);
      default: dpRes = '0;
    endcase
  end

  assign mulOvf = (mulProd[2*WIDTH-1:WIDTH] != {WIDTH{mulProd[WIDTH-1]}});

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    mulStart = 1'b0;
    load     = 1'b0;
    ldRes    = dpRes;
    ldCarry  = dpCarry;
    ldOvf    = dpOvf;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (accept) begin
          if (opE == OP_MUL) begin
            state_d  = ST_MUL;
            mulStart = 1'b1;
          end else begin
            state_d = ST_HOLD;
            load    = 1'b1;
          end
        end else if ((state_q == ST_HOLD) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_MUL: begin
        if (mulDone) begin
          state_d = ST_HOLD;
          load    = 1'b1;
          ldRes   = mulProd[WIDTH-1:0];
          ldCarry = 1'b0;
          ldOvf   = mulOvf;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      result_d      = ldRes;
      flags_d.zero  = (ldRes == '0);
      flags_d.neg   = ldRes[WIDTH-1];
      flags_d.carry = ldCarry;
      flags_d.ovf   = ldOvf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst_n (rst_n),
    .start (mulStart),
    .lhs   (lhs),
    .rhs   (rhs),
    .done  (mulDone),
    .prod  (mulProd)
  );

endmodule
